// File: rtl/axis_upsampler.sv
// ============================================================================
// Module   : axis_upsampler
// Brief    : AXI-Stream upsampler; each input sample is emitted 2^log_factor
//            times, either held or zero-stuffed after the first beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_upsampler #(
    parameter int AXIS_TDATA_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [4:0]                  log_factor,
    input  logic                        zero_stuff,
    output logic                        S_AXIS_tready,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                      state_q,    state_d;
    logic [AXIS_TDATA_WIDTH-1:0] data_q,     data_d;
    logic [31:0]                 rep_cnt_q,  rep_cnt_d;
    logic [31:0]                 last_idx_q, last_idx_d;
    logic                        zstuff_q,   zstuff_d;

    logic w_last_rep;
    logic w_m_hs;
    logic w_s_hs;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_EMPTY;
            data_q     <= '0;
            rep_cnt_q  <= '0;
            last_idx_q <= '0;
            zstuff_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            rep_cnt_q  <= rep_cnt_d;
            last_idx_q <= last_idx_d;
            zstuff_q   <= zstuff_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        rep_cnt_d  = rep_cnt_q;
        last_idx_d = last_idx_q;
        zstuff_d   = zstuff_q;

        w_last_rep    = (rep_cnt_q == last_idx_q);
        w_m_hs        = (state_q == ST_FULL) && M_AXIS_tready;
        // Accept a new sample while empty, or as the final repeat leaves.
        S_AXIS_tready = (state_q == ST_EMPTY) || (w_m_hs && w_last_rep);
        w_s_hs        = S_AXIS_tready && S_AXIS_tvalid;

        M_AXIS_tvalid = (state_q == ST_FULL);
        M_AXIS_tdata  = (!zstuff_q || rep_cnt_q == 32'd0) ? data_q : '0;

        if (w_s_hs) begin
            // Controls are latched only here so mid-sample changes are ignored.
            state_d    = ST_FULL;
            data_d     = S_AXIS_tdata;
            rep_cnt_d  = 32'd0;
            last_idx_d = (32'd1 << log_factor) - 32'd1;
            zstuff_d   = zero_stuff;
        end else if (w_m_hs) begin
            if (w_last_rep) begin
                state_d = ST_EMPTY;
            end else begin
                rep_cnt_d = rep_cnt_q + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_upsampler.sv
// ============================================================================
// Module   : tb_axis_upsampler
// Brief    : Directed self-checking bench for axis_upsampler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_upsampler;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [4:0]  log_factor = 5'd0;
    logic        zero_stuff = 1'b0;
    logic        s_tready;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = 32'd0;
    logic        m_tready = 1'b0;
    logic        m_tvalid;
    logic [31:0] m_tdata;

    int checks = 0;
    int errors = 0;

    axis_upsampler #(.AXIS_TDATA_WIDTH(32)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .log_factor    (log_factor),
        .zero_stuff    (zero_stuff),
        .S_AXIS_tready (s_tready),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tdata  (s_tdata),
        .M_AXIS_tready (m_tready),
        .M_AXIS_tvalid (m_tvalid),
        .M_AXIS_tdata  (m_tdata)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    int          q[$];
    logic [31:0] nxt;
    logic [31:0] prev_data;
    logic        prev_stall;
    logic [31:0] exp_v;

    initial begin
        // Reset asserted between edges must act without a clock
        #2 aresetn = 1'b0;
        #1;
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tdata",  m_tdata, 32'd0);
        chk("rst_tready", {31'd0, s_tready}, 32'd1);
        repeat (2) cyc();
        aresetn = 1'b1;
        cyc();

        // Hold mode, N=4, two back-to-back samples
        log_factor = 5'd2; zero_stuff = 1'b0; m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 32'hA;
        cyc();
        s_tdata = 32'hB;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) s_tvalid = 1'b0;
            #1;
            chk("hold_tvalid", {31'd0, m_tvalid}, 32'd1);
            chk("hold_tdata",  m_tdata, (i < 4) ? 32'hA : 32'hB);
            chk("hold_tready", {31'd0, s_tready}, (i % 4 == 3) ? 32'd1 : 32'd0);
            cyc();
        end
        chk("hold_end_tvalid", {31'd0, m_tvalid}, 32'd0);

        // Zero-stuff mode, N=4
        log_factor = 5'd2; zero_stuff = 1'b1;
        s_tvalid = 1'b1; s_tdata = 32'h5;
        cyc();
        s_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("zs_tvalid", {31'd0, m_tvalid}, 32'd1);
            chk("zs_tdata",  m_tdata, (i == 0) ? 32'h5 : 32'h0);
            cyc();
        end
        chk("zs_end_tvalid", {31'd0, m_tvalid}, 32'd0);

        // N=1 passthrough at full rate
        log_factor = 5'd0; zero_stuff = 1'b0;
        s_tvalid = 1'b1; s_tdata = 32'd1;
        cyc();
        for (int i = 1; i <= 8; i++) begin
            s_tdata  = i + 1;
            s_tvalid = (i < 8);
            #1;
            chk("pt_tvalid", {31'd0, m_tvalid}, 32'd1);
            chk("pt_tdata",  m_tdata, i);
            chk("pt_tready", {31'd0, s_tready}, 32'd1);
            cyc();
        end
        chk("pt_end_tvalid", {31'd0, m_tvalid}, 32'd0);

        // Random backpressure, N=2, scoreboard
        log_factor = 5'd1; zero_stuff = 1'b0;
        nxt = 32'h100; prev_stall = 1'b0; prev_data = 32'd0;
        for (int c = 0; c < 300; c++) begin
            m_tready = ($urandom_range(0, 9) < 3);
            s_tvalid = $urandom_range(0, 1) == 1;
            s_tdata  = nxt;
            #1;
            if (prev_stall) begin
                chk("stall_tvalid", {31'd0, m_tvalid}, 32'd1);
                chk("stall_tdata",  m_tdata, prev_data);
            end
            if (m_tvalid && m_tready) begin
                if (q.size() == 0) chk("sb_extra", {31'd0, m_tvalid}, 32'd0);
                else begin
                    exp_v = q.pop_front();
                    chk("sb_data", m_tdata, exp_v);
                end
            end
            if (s_tvalid && s_tready) begin
                q.push_back(nxt);
                q.push_back(nxt);
                nxt++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            cyc();
        end
        m_tready = 1'b1; s_tvalid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_tvalid) begin
                if (q.size() == 0) chk("sb_extra", {31'd0, m_tvalid}, 32'd0);
                else begin
                    exp_v = q.pop_front();
                    chk("sb_data", m_tdata, exp_v);
                end
            end
            cyc();
        end
        chk("sb_leftover", q.size(), 32'd0);
        chk("sb_drain_tvalid", {31'd0, m_tvalid}, 32'd0);

        // log_factor change mid-sample does not affect the held sample
        log_factor = 5'd3; zero_stuff = 1'b0; m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 32'h11;
        cyc();
        s_tdata = 32'h22;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) log_factor = 5'd1;
            chk("lfchg_a", m_tdata, 32'h11);
            cyc();
        end
        s_tvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("lfchg_b_tvalid", {31'd0, m_tvalid}, 32'd1);
            chk("lfchg_b", m_tdata, 32'h22);
            cyc();
        end
        chk("lfchg_end_tvalid", {31'd0, m_tvalid}, 32'd0);

        // Reset mid-repetition discards the sample
        log_factor = 5'd3;
        s_tvalid = 1'b1; s_tdata = 32'h33;
        cyc();
        s_tvalid = 1'b0;
        chk("mrst_beat0", m_tdata, 32'h33);
        cyc();
        aresetn = 1'b0;
        #1;
        chk("mrst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("mrst_tdata",  m_tdata, 32'd0);
        chk("mrst_tready", {31'd0, s_tready}, 32'd1);
        cyc();
        aresetn = 1'b1;
        cyc();
        chk("mrst_idle_tvalid", {31'd0, m_tvalid}, 32'd0);
        s_tvalid = 1'b1; s_tdata = 32'h44;
        cyc();
        s_tvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("mrst_new_tvalid", {31'd0, m_tvalid}, 32'd1);
            chk("mrst_new", m_tdata, 32'h44);
            cyc();
        end
        chk("mrst_end_tvalid", {31'd0, m_tvalid}, 32'd0);

        // Maximum factor: counter keeps running without an early last beat
        log_factor = 5'd31; zero_stuff = 1'b1;
        s_tvalid = 1'b1; s_tdata = 32'h77;
        cyc();
        s_tvalid = 1'b0;
        chk("max_first", m_tdata, 32'h77);
        for (int i = 0; i < 40; i++) begin
            #1;
            chk("max_tvalid", {31'd0, m_tvalid}, 32'd1);
            chk("max_tready", {31'd0, s_tready}, 32'd0);
            cyc();
        end
        chk("max_zero", m_tdata, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
